// File: rtl/miriscv_irq_pkg.sv
// miriscv_irq_pkg: shared types and constants for the interrupt controller
package miriscv_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ACTIVE,
        IRQ_FIN
    } irq_state_e;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int IRQ_ID_W       = 5;

    // mcause for an interrupt: interrupt flag on top, 31-bit wrapping code below
    function automatic logic [31:0] irq_mcause(input logic [31:0] base, input logic [IRQ_ID_W-1:0] id);
        logic [31:0] code;
        code = base + 32'(id);
        irq_mcause = {1'b1, code[MCAUSE_INT_BIT-1:0]};
    endfunction

endpackage

// File: rtl/miriscv_prio_enc.sv
// miriscv_prio_enc: lowest-set-bit priority encoder, index 0 has highest priority
module miriscv_prio_enc
    import miriscv_irq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]          req,
    output logic                  valid,
    output logic [IRQ_ID_W-1:0]   id
);

    // scan from the top down so the lowest set index wins
    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) id = IRQ_ID_W'(i);
        valid = |req;
    end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: picks one enabled request, holds int_o to the core, pulses completion on mret
module miriscv_irq_ctrl
    import miriscv_irq_pkg::*;
#(
    parameter int          IRQ_NUM     = 32,
    parameter logic [31:0] MCAUSE_BASE = 32'h0000_0010
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [IRQ_NUM-1:0] int_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic               int_rst_i,
    output logic               int_o,
    output logic [31:0]        mcause_o,
    output logic [IRQ_NUM-1:0] int_fin_o
);

    irq_state_e          state;
    irq_state_e          state_next;
    logic                enc_valid;
    logic [IRQ_ID_W-1:0] enc_id;
    logic [IRQ_ID_W-1:0] id;
    logic [31:0]         mcause;

    miriscv_prio_enc #(.N(IRQ_NUM)) u_enc (
        .req   (int_req_i & mie_i),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // state register; reset abandons any service in progress without a completion
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) state <= IRQ_IDLE;
        else          state <= state_next;

    // next state: take a request from IDLE, wait for mret in ACTIVE, FIN lasts one cycle
    always_comb begin
        state_next = IRQ_IDLE;
        case (state)
            IRQ_IDLE:   state_next = enc_valid ? IRQ_ACTIVE : IRQ_IDLE;
            IRQ_ACTIVE: state_next = int_rst_i ? IRQ_FIN : IRQ_ACTIVE;
            default:    state_next = IRQ_IDLE;
        endcase
    end

    // latch the serviced id and its mcause only on the IDLE->ACTIVE decision
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            id     <= '0;
            mcause <= '0;
        end else if (state == IRQ_IDLE && enc_valid) begin
            id     <= enc_id;
            mcause <= irq_mcause(MCAUSE_BASE, enc_id);
        end

    // outputs decoded from registered state, so they change only on clock or reset
    always_comb begin
        int_o     = (state == IRQ_ACTIVE);
        mcause_o  = mcause;
        int_fin_o = (state == IRQ_FIN) ? (IRQ_NUM'(1) << id) : '0;
    end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// tb_miriscv_irq_ctrl: directed scoreboard bench for the interrupt controller
module tb_miriscv_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic [31:0] mie = '0;
    logic        irst = 1'b0;
    logic        int_o;
    logic [31:0] mcause;
    logic [31:0] fin;

    typedef struct {
        string       tag;
        logic        io;
        logic [31:0] mc;
        logic [31:0] fn;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    miriscv_irq_ctrl dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .int_req_i (req),
        .mie_i     (mie),
        .int_rst_i (irst),
        .int_o     (int_o),
        .mcause_o  (mcause),
        .int_fin_o (fin)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic io, input logic [31:0] mc, input logic [31:0] fn);
        exp_t e;
        e.tag = tag;
        e.io  = io;
        e.mc  = mc;
        e.fn  = fn;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("FAIL scoreboard: queue empty, got size %0d expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests_run += 3;
            assert (int_o === e.io) else begin
                tests_failed++;
                $error("FAIL %s int_o: got %b expected %b", e.tag, int_o, e.io);
            end
            assert (mcause === e.mc) else begin
                tests_failed++;
                $error("FAIL %s mcause: got %h expected %h", e.tag, mcause, e.mc);
            end
            assert (fin === e.fn) else begin
                tests_failed++;
                $error("FAIL %s int_fin: got %h expected %h", e.tag, fin, e.fn);
            end
        end
    endtask

    task automatic tick(input string tag, input logic io, input logic [31:0] mc, input logic [31:0] fn);
        expect_out(tag, io, mc, fn);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 32'h0, 32'h0);
        check_now();
        rst_n = 1'b1;
        tick("idle0", 1'b0, 32'h0, 32'h0);

        // 1: single request on line 19
        mie = 32'h0008_0000;
        req = 32'h0008_0000;
        for (int i = 0; i < 14; i++) tick("t1_act", 1'b1, 32'h8000_0023, 32'h0);
        irst = 1'b1;
        tick("t1_fin", 1'b0, 32'h8000_0023, 32'h0008_0000);
        irst = 1'b0;
        req  = '0;
        tick("t1_idle", 1'b0, 32'h8000_0023, 32'h0);
        tick("t1_idle2", 1'b0, 32'h8000_0023, 32'h0);

        // 2: simultaneous requests 10 and 11, lowest index first
        mie = '1;
        req = 32'h0000_0C00;
        tick("t2_act10", 1'b1, 32'h8000_001A, 32'h0);
        tick("t2_hold10", 1'b1, 32'h8000_001A, 32'h0);
        irst = 1'b1;
        tick("t2_fin10", 1'b0, 32'h8000_001A, 32'h0000_0400);
        irst = 1'b0;
        req  = 32'h0000_0800;
        tick("t2_gap", 1'b0, 32'h8000_001A, 32'h0);
        tick("t2_act11", 1'b1, 32'h8000_001B, 32'h0);
        irst = 1'b1;
        tick("t2_fin11", 1'b0, 32'h8000_001B, 32'h0000_0800);
        irst = 1'b0;
        req  = '0;
        tick("t2_idle", 1'b0, 32'h8000_001B, 32'h0);

        // 3: masked request, then enabled, then mask dropped while active
        mie = '0;
        req = 32'h0000_0020;
        for (int i = 0; i < 50; i++) tick("t3_masked", 1'b0, 32'h8000_001B, 32'h0);
        mie = 32'h0000_0020;
        tick("t3_act", 1'b1, 32'h8000_0015, 32'h0);
        mie = '0;
        for (int i = 0; i < 3; i++) tick("t3_unmask", 1'b1, 32'h8000_0015, 32'h0);
        irst = 1'b1;
        tick("t3_fin", 1'b0, 32'h8000_0015, 32'h0000_0020);
        irst = 1'b0;
        req  = '0;
        tick("t3_idle", 1'b0, 32'h8000_0015, 32'h0);

        // 4: request dropped while active, held for 100 cycles
        mie = '1;
        req = 32'h0000_0008;
        tick("t4_act", 1'b1, 32'h8000_0013, 32'h0);
        req = '0;
        for (int i = 0; i < 100; i++) tick("t4_hold", 1'b1, 32'h8000_0013, 32'h0);
        irst = 1'b1;
        tick("t4_fin", 1'b0, 32'h8000_0013, 32'h0000_0008);
        irst = 1'b0;
        tick("t4_idle", 1'b0, 32'h8000_0013, 32'h0);

        // 5: async reset mid-service, pending request re-taken after release
        req = 32'h0000_0080;
        tick("t5_act", 1'b1, 32'h8000_0017, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("t5_async", 1'b0, 32'h0, 32'h0);
        check_now();
        tick("t5_inrst", 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick("t5_retake", 1'b1, 32'h8000_0017, 32'h0);
        irst = 1'b1;
        tick("t5_fin", 1'b0, 32'h8000_0017, 32'h0000_0080);
        irst = 1'b0;
        req  = '0;
        tick("t5_idle", 1'b0, 32'h8000_0017, 32'h0);

        // 6: mret pulse while idle with nothing pending
        irst = 1'b1;
        tick("t6_ign", 1'b0, 32'h8000_0017, 32'h0);
        irst = 1'b0;
        tick("t6_idle", 1'b0, 32'h8000_0017, 32'h0);

        // mret coinciding with the IDLE->ACTIVE decision is ignored
        req  = 32'h0000_0004;
        irst = 1'b1;
        tick("t7_act", 1'b1, 32'h8000_0012, 32'h0);
        irst = 1'b0;
        tick("t7_hold", 1'b1, 32'h8000_0012, 32'h0);
        irst = 1'b1;
        tick("t7_fin", 1'b0, 32'h8000_0012, 32'h0000_0004);
        irst = 1'b0;
        req  = '0;
        tick("t7_idle", 1'b0, 32'h8000_0012, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
